// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rf_pkg
//  Description : Shared sizing constants and types for the 2R1W register file.
//  Revision    : 1.0  - initial release
// ============================================================================
package rf_pkg;

    localparam int NUM_REGS   = 32;
    localparam int DATA_WIDTH = 64;
    localparam int ADDR_WIDTH = $clog2(NUM_REGS);

    typedef logic [ADDR_WIDTH-1:0] rf_addr_t;
    typedef logic [DATA_WIDTH-1:0] rf_data_t;

endpackage : rf_pkg
`default_nettype wire

// File: rtl/rf_read_port.sv
`default_nettype none
// ============================================================================
//  Module      : rf_read_port
//  Description : One registered read port with write-first bypass. When the
//                port is enabled and the same-cycle write targets the address
//                being read, the incoming write data is returned instead of
//                the (stale) stored value.
//  Revision    : 1.0  - initial release
// ============================================================================
module rf_read_port
    import rf_pkg::*;
(
    input  logic     clk,
    input  logic     reset_n,
    input  logic     read_en_i,
    input  rf_addr_t raddr_i,
    input  rf_data_t rf_rdata_i,
    input  logic     write_en_i,
    input  rf_addr_t waddr_i,
    input  rf_data_t wdata_i,
    output rf_data_t rdata_o
);

    rf_data_t rdata_d;
    rf_data_t rdata_q;

    // Next read data: hold when disabled, otherwise bypass or array value
    always_comb begin
        rdata_d = rdata_q;
        if (read_en_i) begin
            if (write_en_i && (waddr_i == raddr_i)) begin
                rdata_d = wdata_i;
            end else begin
                rdata_d = rf_rdata_i;
            end
        end
    end

    // Output register, cleared immediately on reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule : rf_read_port
`default_nettype wire

// File: rtl/register_file_2r1w.sv
`default_nettype none
// ============================================================================
//  Module      : register_file_2r1w
//  Description : NUM_REGS x DATA_WIDTH register file with two registered
//                read ports and one write port. Every entry, including
//                index 0, is writable. All state clears asynchronously.
//  Revision    : 1.0  - initial release
// ============================================================================
module register_file_2r1w
    import rf_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] read_en,
    input  logic       write_en,
    input  rf_addr_t   raddr_0,
    input  rf_addr_t   raddr_1,
    input  rf_addr_t   waddr,
    input  rf_data_t   wdata,
    output rf_data_t   rdata_0,
    output rf_data_t   rdata_1
);

    // Storage array; name kept as RF so it can be inspected hierarchically
    rf_data_t RF [0:NUM_REGS-1];

    // Write port; reset clears every entry and discards a same-cycle write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                RF[i] <= '0;
            end
        end else if (write_en) begin
            RF[waddr] <= wdata;
        end
    end

    rf_read_port u_rd_port0 (
        .clk        (clk),
        .reset_n    (reset_n),
        .read_en_i  (read_en[0]),
        .raddr_i    (raddr_0),
        .rf_rdata_i (RF[raddr_0]),
        .write_en_i (write_en),
        .waddr_i    (waddr),
        .wdata_i    (wdata),
        .rdata_o    (rdata_0)
    );

    rf_read_port u_rd_port1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .read_en_i  (read_en[1]),
        .raddr_i    (raddr_1),
        .rf_rdata_i (RF[raddr_1]),
        .write_en_i (write_en),
        .waddr_i    (waddr),
        .wdata_i    (wdata),
        .rdata_o    (rdata_1)
    );

endmodule : register_file_2r1w
`default_nettype wire

// File: tb/tb_register_file_2r1w.sv
`default_nettype none
// ============================================================================
//  Module      : tb_register_file_2r1w
//  Description : Self-checking bench for register_file_2r1w. Directed steps
//                followed by random traffic, compared against an array-based
//                behavioural model of the register file.
//  Revision    : 1.0  - initial release
// ============================================================================
module tb_register_file_2r1w;

    logic        clk;
    logic        reset_n;
    logic [1:0]  read_en;
    logic        write_en;
    logic [4:0]  raddr_0;
    logic [4:0]  raddr_1;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic [63:0] rdata_0;
    logic [63:0] rdata_1;

    // Behavioural model
    logic [63:0] mem [32];
    logic [63:0] m_r0;
    logic [63:0] m_r1;

    int n_pass;
    int n_checks;

    register_file_2r1w dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .read_en  (read_en),
        .write_en (write_en),
        .raddr_0  (raddr_0),
        .raddr_1  (raddr_1),
        .waddr    (waddr),
        .wdata    (wdata),
        .rdata_0  (rdata_0),
        .rdata_1  (rdata_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mem[i] = 64'h0;
        m_r0 = 64'h0;
        m_r1 = 64'h0;
    endtask

    // Apply one cycle of inputs, advance the model at the edge, then compare
    task automatic cycle(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                         input logic [1:0] re, input logic [4:0] ra0, input logic [4:0] ra1);
        int k;
        write_en = we;
        waddr    = wa;
        wdata    = wd;
        read_en  = re;
        raddr_0  = ra0;
        raddr_1  = ra1;
        @(posedge clk);
        // Write-first semantics: a read sees the value written this cycle
        if (re[0]) m_r0 = (we && wa == ra0) ? wd : mem[ra0];
        if (re[1]) m_r1 = (we && wa == ra1) ? wd : mem[ra1];
        if (we) mem[wa] = wd;
        #1;
        check("rdata_0", rdata_0, m_r0);
        check("rdata_1", rdata_1, m_r1);
        k = $urandom_range(0, 31);
        check($sformatf("RF[%0d]", k), dut.RF[k], mem[k]);
    endtask

    function automatic logic [4:0] rand_addr();
        // Half the traffic hits a small window so bypass collisions are frequent
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 3));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        n_pass   = 0;
        n_checks = 0;
        reset_n  = 1'b0;
        read_en  = 2'b00;
        write_en = 1'b0;
        raddr_0  = '0;
        raddr_1  = '0;
        waddr    = '0;
        wdata    = '0;
        model_clear();

        // 1. Reset defaults
        #100;
        for (int i = 0; i < 32; i++) check($sformatf("reset RF[%0d]", i), dut.RF[i], 64'h0);
        check("reset rdata_0", rdata_0, 64'h0);
        check("reset rdata_1", rdata_1, 64'h0);
        #2;
        reset_n = 1'b1;

        // 2. Write then read on port 0 only
        cycle(1'b1, 5'd5, 64'hDEAD_BEEF_0123_4567, 2'b00, 5'd0, 5'd0);
        cycle(1'b0, 5'd0, 64'h0, 2'b01, 5'd5, 5'd5);
        check("wr-rd rdata_0", rdata_0, 64'hDEAD_BEEF_0123_4567);
        check("wr-rd rdata_1 unchanged", rdata_1, 64'h0);

        // 3. Dual read of distinct addresses
        cycle(1'b1, 5'd1, 64'h1, 2'b00, 5'd0, 5'd0);
        cycle(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 5'd0, 5'd0);
        cycle(1'b0, 5'd0, 64'h0, 2'b11, 5'd1, 5'd31);
        check("dual rdata_0", rdata_0, 64'h1);
        check("dual rdata_1", rdata_1, 64'hFFFF_FFFF_FFFF_FFFF);

        // 4. Write-first bypass on both ports
        cycle(1'b1, 5'd7, 64'hA5A5, 2'b11, 5'd7, 5'd7);
        check("bypass rdata_0", rdata_0, 64'hA5A5);
        check("bypass rdata_1", rdata_1, 64'hA5A5);

        // 5. Hold while addresses move
        cycle(1'b0, 5'd0, 64'h0, 2'b00, 5'd1, 5'd31);
        cycle(1'b0, 5'd0, 64'h0, 2'b00, 5'd5, 5'd0);
        check("hold rdata_0", rdata_0, 64'hA5A5);
        check("hold rdata_1", rdata_1, 64'hA5A5);

        // Index 0 is an ordinary register
        cycle(1'b1, 5'd0, 64'h0BAD_F00D, 2'b00, 5'd0, 5'd0);
        cycle(1'b0, 5'd0, 64'h0, 2'b10, 5'd0, 5'd0);
        check("reg0 rdata_1", rdata_1, 64'h0BAD_F00D);

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            cycle(1'($urandom_range(0, 1)), rand_addr(), {$urandom, $urandom},
                  2'($urandom_range(0, 3)), rand_addr(), rand_addr());
        end

        // 6. Fill every register with nonzero data, then asynchronous reset
        for (int i = 0; i < 32; i++) begin
            cycle(1'b1, 5'(i), {$urandom, $urandom} | 64'h1, 2'b11, 5'(i), 5'(31 - i));
        end
        write_en = 1'b1;
        waddr    = 5'd3;
        wdata    = 64'h1234_5678_9ABC_DEF0;
        read_en  = 2'b11;
        #3;
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) check($sformatf("async RF[%0d]", i), dut.RF[i], 64'h0);
        check("async rdata_0", rdata_0, 64'h0);
        check("async rdata_1", rdata_1, 64'h0);
        // Hold reset across an edge with a write pending: it must be discarded
        @(posedge clk);
        #1;
        check("discard RF[3]", dut.RF[3], 64'h0);
        check("held rdata_0", rdata_0, 64'h0);
        #3;
        reset_n = 1'b1;
        model_clear();

        // Post-reset random traffic
        for (int n = 0; n < 100; n++) begin
            cycle(1'($urandom_range(0, 1)), rand_addr(), {$urandom, $urandom},
                  2'($urandom_range(0, 3)), rand_addr(), rand_addr());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_register_file_2r1w
`default_nettype wire
